// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush/redirect controller; stall watchdog built when PIPE_CTRL_WDOG_EN is defined
module pipe_ctrl #(
    parameter int NUM_STAGES = 6,
    parameter int ADDR_W = 32,
    parameter logic [ADDR_W-1:0] EXC_VECTOR = 32'hBFC00380,
    parameter int FLUSH_LEN = 1,
    parameter int WDOG_LIMIT = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_STAGES-1:0] stall_req,
    input  logic                  except_valid,
    input  logic                  eret,
    input  logic [ADDR_W-1:0]     epc,
    output logic [NUM_STAGES-1:0] stall,
    output logic                  flush,
    output logic [ADDR_W-1:0]     flush_pc,
    output logic                  busy,
    output logic                  wdog_timeout
);
    localparam int FW = $clog2(FLUSH_LEN + 1);
    typedef enum logic {RUN, FLUSH} state_t;
    state_t state, state_nx;
    logic [FW-1:0] fcnt, fcnt_nx;
    logic [ADDR_W-1:0] pc_nx;
    logic [NUM_STAGES-1:0] stall_raw;
    logic wexp;
    genvar i;
    for (i = 0; i < NUM_STAGES; i++) begin : g_stall
        assign stall_raw[i] = |stall_req[NUM_STAGES-1:i];
    end
    assign stall = (reset || state == FLUSH || except_valid || eret) ? '0 : stall_raw;
    assign busy = state == FLUSH;
    assign flush = busy;
`ifdef PIPE_CTRL_WDOG_EN
    localparam int WW = $clog2(WDOG_LIMIT);
    logic [WW-1:0] wcnt;
    assign wexp = |stall && wcnt == WW'(WDOG_LIMIT - 1);
    // count consecutive stalled cycles; any unstalled cycle or expiry restarts the count
    always_ff @(posedge clk) begin
        wcnt <= (reset || ~|stall || wexp) ? '0 : wcnt + 1'b1;
        wdog_timeout <= !reset && wexp;
    end
`else
    assign wexp = 1'b0;
    assign wdog_timeout = 1'b0 & (WDOG_LIMIT < 0);
`endif
    // next state: enter FLUSH on exception/eret/watchdog, leave after FLUSH_LEN cycles
    always_comb begin
        state_nx = state;
        fcnt_nx = fcnt;
        pc_nx = flush_pc;
        if (state == RUN) begin
            if (except_valid || eret || wexp) begin
                state_nx = FLUSH;
                fcnt_nx = FW'(FLUSH_LEN);
                pc_nx = (eret && !except_valid) ? epc : EXC_VECTOR;
            end
        end else begin
            fcnt_nx = fcnt - 1'b1;
            state_nx = (fcnt == FW'(1)) ? RUN : FLUSH;
        end
    end
    // state, flush counter and redirect target registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            fcnt <= '0;
            flush_pc <= '0;
        end else begin
            state <= state_nx;
            fcnt <= fcnt_nx;
            flush_pc <= pc_nx;
        end
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and randomized checks of pipe_ctrl against a cycle-level behavioural model
module tb_pipe_ctrl;
    localparam int FL = 3;
    localparam int WL = 8;
    localparam logic [31:0] EXC = 32'hBFC00380;
`ifdef PIPE_CTRL_WDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif
    logic clk = 0;
    logic reset = 0;
    logic [5:0] stall_req = 0;
    logic except_valid = 0, eret = 0;
    logic [31:0] epc = 0;
    logic [5:0] stall;
    logic flush, busy, wdog_timeout;
    logic [31:0] flush_pc;
    int checks = 0, failures = 0;
    int m_left = 0, m_wd = 0;
    logic [31:0] m_pc = 0;
    logic m_to = 0;
    logic [5:0] es;

    pipe_ctrl #(.NUM_STAGES(6), .ADDR_W(32), .EXC_VECTOR(EXC), .FLUSH_LEN(FL), .WDOG_LIMIT(WL)) dut (
        .clk(clk), .reset(reset), .stall_req(stall_req), .except_valid(except_valid), .eret(eret),
        .epc(epc), .stall(stall), .flush(flush), .flush_pc(flush_pc), .busy(busy), .wdog_timeout(wdog_timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] exp_stall();
        int k = -1;
        for (int j = 0; j < 6; j++) if (stall_req[j]) k = j;
        if (reset || m_left > 0 || except_valid || eret || k < 0) return 6'd0;
        return 6'((1 << (k + 1)) - 1);
    endfunction

    task automatic drive(input logic [5:0] r, input logic e, input logic t, input logic [31:0] p, input logic x);
        stall_req = r; except_valid = e; eret = t; epc = p; reset = x;
        #1;
        es = exp_stall();
    endtask

    task automatic advance();
        logic [5:0] s = exp_stall();
        m_to = 0;
        if (reset) begin
            m_left = 0; m_pc = 0; m_wd = 0;
        end else if (m_left > 0) begin
            m_left--; m_wd = 0;
        end else if (except_valid || eret) begin
            m_left = FL; m_pc = except_valid ? EXC : epc; m_wd = 0;
        end else if (s == 0) begin
            m_wd = 0;
        end else if (WD && m_wd == WL - 1) begin
            m_to = 1; m_left = FL; m_pc = EXC; m_wd = 0;
        end else begin
            m_wd++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        for (int j = 0; j < 10 && m_left > 0; j++) begin
            drive(0, 0, 0, 0, 0);
            advance();
        end
    endtask

    task automatic test_reset();
        drive(6'h3f, 0, 0, 0, 1);
        advance();
        drive(6'h3f, 0, 0, 0, 1);
        checks += 5;
        if (stall !== 6'h00) begin failures++; $display("FAIL reset_stall got=%h exp=00", stall); end
        if (flush !== 1'b0) begin failures++; $display("FAIL reset_flush got=%b exp=0", flush); end
        if (flush_pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", flush_pc); end
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (wdog_timeout !== 1'b0) begin failures++; $display("FAIL reset_wdog got=%b exp=0", wdog_timeout); end
        advance();
        drive(6'h3f, 0, 0, 0, 0);
        checks++;
        if (stall !== 6'h3f) begin failures++; $display("FAIL release_stall got=%h exp=3f", stall); end
        advance();
    endtask

    task automatic test_stall_vector();
        logic [5:0] reqs [3] = '{6'b001000, 6'b000101, 6'b000000};
        logic [5:0] exps [3] = '{6'b001111, 6'b000111, 6'b000000};
        drive(0, 0, 0, 0, 1);
        advance();
        for (int j = 0; j < 3; j++) begin
            drive(reqs[j], 0, 0, 0, 0);
            checks++;
            if (stall !== exps[j]) begin failures++; $display("FAIL stall_vec%0d got=%h exp=%h", j, stall, exps[j]); end
            advance();
        end
    endtask

    task automatic test_flush_len();
        idle();
        drive(0, 1, 0, 0, 0);
        advance();
        for (int j = 1; j <= 4; j++) begin
            drive(6'h3f, j == 2, 0, 0, 0);
            checks += 2;
            if (flush !== (j <= 3)) begin failures++; $display("FAIL flush_len_t%0d got=%b exp=%b", j, flush, j <= 3); end
            if (busy !== (j <= 3)) begin failures++; $display("FAIL busy_len_t%0d got=%b exp=%b", j, busy, j <= 3); end
            if (j <= 3) begin
                checks += 2;
                if (flush_pc !== EXC) begin failures++; $display("FAIL flush_pc_t%0d got=%h exp=%h", j, flush_pc, EXC); end
                if (stall !== 6'h00) begin failures++; $display("FAIL stall_in_flush_t%0d got=%h exp=00", j, stall); end
            end
            advance();
        end
    endtask

    task automatic test_eret();
        idle();
        drive(0, 0, 1, 32'h80001000, 0);
        advance();
        drive(0, 0, 0, 0, 0);
        checks += 2;
        if (flush !== 1'b1) begin failures++; $display("FAIL eret_flush got=%b exp=1", flush); end
        if (flush_pc !== 32'h80001000) begin failures++; $display("FAIL eret_pc got=%h exp=80001000", flush_pc); end
        advance();
        idle();
        drive(6'h3f, 1, 1, 32'h12345678, 0);
        checks++;
        if (stall !== 6'h00) begin failures++; $display("FAIL both_stall got=%h exp=00", stall); end
        advance();
        drive(0, 0, 0, 0, 0);
        checks += 2;
        if (flush !== 1'b1) begin failures++; $display("FAIL both_flush got=%b exp=1", flush); end
        if (flush_pc !== EXC) begin failures++; $display("FAIL both_pc got=%h exp=%h", flush_pc, EXC); end
        advance();
        idle();
    endtask

    task automatic test_wdog();
        drive(6'b000100, 0, 0, 0, 1);
        advance();
        for (int c = 0; c < (WD ? 13 : 100); c++) begin
            drive(6'b000100, 0, 0, 0, 0);
            checks++;
            if (wdog_timeout !== (WD && c == 8)) begin
                failures++; $display("FAIL wdog_c%0d got=%b exp=%b", c, wdog_timeout, WD && c == 8);
            end
            if (WD) begin
                checks++;
                if (flush !== (c >= 8 && c < 8 + FL)) begin
                    failures++; $display("FAIL wdog_flush_c%0d got=%b exp=%b", c, flush, c >= 8 && c < 8 + FL);
                end
                if (c == 8) begin
                    checks++;
                    if (flush_pc !== EXC) begin failures++; $display("FAIL wdog_pc got=%h exp=%h", flush_pc, EXC); end
                end
            end
            advance();
        end
    endtask

    task automatic test_reset_mid_flush();
        drive(0, 0, 0, 0, 1);
        advance();
        drive(0, 0, 1, 32'h80002000, 0);
        advance();
        drive(0, 0, 0, 0, 0);
        advance();
        drive(0, 0, 0, 0, 1);
        checks++;
        if (flush !== 1'b1) begin failures++; $display("FAIL mid_flush_before got=%b exp=1", flush); end
        advance();
        drive(0, 0, 0, 0, 0);
        checks += 3;
        if (flush !== 1'b0) begin failures++; $display("FAIL mid_flush got=%b exp=0", flush); end
        if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", busy); end
        if (flush_pc !== 32'h0) begin failures++; $display("FAIL mid_pc got=%h exp=0", flush_pc); end
        advance();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            logic dense = c >= 200;
            drive(($urandom % (dense ? 8 : 3) != 0) == dense ? 6'($urandom) : 6'd0,
                  $urandom % (dense ? 40 : 16) == 0, $urandom % (dense ? 40 : 12) == 0,
                  $urandom, $urandom % 50 == 0);
            checks += 5;
            if (stall !== es) begin failures++; $display("FAIL rnd_stall c=%0d got=%h exp=%h", c, stall, es); end
            if (flush !== (m_left > 0)) begin failures++; $display("FAIL rnd_flush c=%0d got=%b exp=%b", c, flush, m_left > 0); end
            if (busy !== (m_left > 0)) begin failures++; $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, busy, m_left > 0); end
            if (flush_pc !== m_pc) begin failures++; $display("FAIL rnd_pc c=%0d got=%h exp=%h", c, flush_pc, m_pc); end
            if (wdog_timeout !== m_to) begin failures++; $display("FAIL rnd_wdog c=%0d got=%b exp=%b", c, wdog_timeout, m_to); end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_stall_vector();
        test_flush_len();
        test_eret();
        test_wdog();
        test_reset_mid_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
